// File: rtl/fpaddsub_pkg.sv
// Shared widths, constants and pipeline payload types for the FP add/sub back end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fpaddsub_pkg;

    localparam int EXP_W    = 8;          // exponent width
    localparam int FRAC_W   = 23;         // stored fraction width
    localparam int SUM_W    = 50;         // {carry, hidden, 48 fraction+guard bits}
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int LZC_W    = 6;          // holds 0..49
    localparam int NRM_W    = SUM_W - 1;  // normalized mantissa incl. hidden bit
    localparam int EI_W     = EXP_W + 2;  // signed intermediate exponent, -49..257

    // S1 payload: raw sum plus its carry and leading-zero count
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SUM_W-1:0]  sum;
        logic              c;
        logic [LZC_W-1:0]  z;
        logic              zero;
    } s1_t;

    // S2 payload: normalized mantissa (hidden bit at MSB) and adjusted exponent
    typedef struct packed {
        logic                   sign;
        logic signed [EI_W-1:0] ei;
        logic [NRM_W-1:0]       n;
        logic                   sticky0;
    } s2_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
        logic inexact;
    } flags_t;

endpackage

// File: rtl/fpaddsub_lzc.sv
// Leading-zero counter over the 49-bit {hidden, fraction} field; returns 49 for an all-zero input.
// Latency: combinational.
// Backpressure: none (pure function of vec_i).
// Ports: vec_i - bits to scan (MSB first); lzc_o - number of leading zeros.
module fpaddsub_lzc
    import fpaddsub_pkg::*;
(
    input  logic [NRM_W-1:0] vec_i,
    output logic [LZC_W-1:0] lzc_o
);

    // Scan upward so the highest set bit is the last to write the result.
    always_comb begin
        lzc_o = LZC_W'(NRM_W);
        for (int i = 0; i < NRM_W; i++) begin
            if (vec_i[i]) begin
                lzc_o = LZC_W'(NRM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_round.sv
// Normalize / round-to-nearest-even / pack back end of the single-precision adder (LZC, shift, round stages).
// Latency: 3 clk from accept to out_valid, 1 beat/clk, bubbles kept in place.
// Backpressure: out_valid & ~out_ready freezes all three stages and drops in_ready combinationally.
// Ports: clk/rst_n (sync active-low); in_valid/in_ready + in_sign/in_exp/in_sum in;
//        out_valid/out_ready + out_result and ovf/unf/zero/inexact flags out.
module fpaddsub_normalize_round
    import fpaddsub_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [SUM_W-1:0]   in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_ovf,
    output logic               out_unf,
    output logic               out_zero,
    output logic               out_inexact
);

    localparam int G_BIT = NRM_W - 2 - FRAC_W;  // guard position in N (24)
    localparam logic signed [EI_W-1:0] EI_ZERO = '0;
    localparam logic signed [EI_W-1:0] EI_MAX  = EI_W'(EXP_MAX);

    logic       stall;
    logic       v1_q, v2_q, v3_q;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic [31:0] res_d, res_q;
    flags_t     flg_d, flg_q;
    logic [LZC_W-1:0] lzc_z;

    assign stall    = v3_q & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: leading-zero count ----------------
    fpaddsub_lzc u_lzc (
        .vec_i (in_sum[NRM_W-1:0]),
        .lzc_o (lzc_z)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.exp  = in_exp;
        s1_d.sum  = in_sum;
        s1_d.c    = in_sum[SUM_W-1];
        s1_d.z    = lzc_z;
        s1_d.zero = (in_sum == '0);
    end

    // ---------------- S2: normalize shift ----------------
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        if (s1_q.c) begin
            s2_d.n       = s1_q.sum[SUM_W-1:1];
            s2_d.sticky0 = s1_q.sum[0];
            s2_d.ei      = $signed({2'b00, s1_q.exp}) + $signed(EI_W'(1));
        end else begin
            s2_d.n       = s1_q.sum[NRM_W-1:0] << s1_q.z;
            s2_d.sticky0 = 1'b0;
            s2_d.ei      = $signed({2'b00, s1_q.exp})
                         - $signed({{(EI_W-LZC_W){1'b0}}, s1_q.z});
        end
        // A zero sum carries no meaningful exponent; park it at 0 so S3 only
        // ever sees the exponent of a real value.
        if (s1_q.zero) begin
            s2_d.ei = '0;
        end
    end

    // ---------------- S3: round to nearest even and pack ----------------
    logic [FRAC_W-1:0]      frac;
    logic                   g_bit, s_bit, rnd_up, is_zero;
    logic [FRAC_W:0]        f_rnd;
    logic signed [EI_W-1:0] ei_r;

    always_comb begin
        frac    = s2_q.n[G_BIT+FRAC_W:G_BIT+1];
        g_bit   = s2_q.n[G_BIT];
        s_bit   = (|s2_q.n[G_BIT-1:0]) | s2_q.sticky0;
        rnd_up  = g_bit & (s_bit | frac[0]);
        // After normalization only a zero sum lacks the hidden bit.
        is_zero = ~s2_q.n[NRM_W-1];
        f_rnd   = {1'b0, frac} + (FRAC_W+1)'(rnd_up);
        // Fraction carry-out leaves the fraction at zero and bumps the exponent.
        ei_r    = s2_q.ei + $signed({{(EI_W-1){1'b0}}, f_rnd[FRAC_W]});

        flg_d         = '0;
        flg_d.inexact = g_bit | s_bit;
        res_d         = {s2_q.sign, ei_r[EXP_W-1:0], f_rnd[FRAC_W-1:0]};
        if (is_zero) begin
            res_d         = '0;
            flg_d         = '0;
            flg_d.zero    = 1'b1;
        end else if (ei_r <= EI_ZERO) begin
            res_d         = {s2_q.sign, 31'b0};
            flg_d.unf     = 1'b1;
            flg_d.inexact = 1'b1;
        end else if (ei_r >= EI_MAX) begin
            res_d         = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flg_d.ovf     = 1'b1;
            flg_d.inexact = 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else if (!stall) begin
            v1_q  <= in_valid;
            s1_q  <= s1_d;
            v2_q  <= v1_q;
            s2_q  <= s2_d;
            v3_q  <= v2_q;
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    assign out_valid   = v3_q;
    assign out_result  = res_q;
    assign out_ovf     = flg_q.ovf;
    assign out_unf     = flg_q.unf;
    assign out_zero    = flg_q.zero;
    assign out_inexact = flg_q.inexact;

endmodule

// File: tb/tb_fpaddsub_normalize_round.sv
// Bench for fpaddsub_normalize_round: directed corner vectors, randomized traffic with random
// output backpressure checked against an arithmetic reference model, a stall burst and a mid-stream reset.
module tb_fpaddsub_normalize_round;
    import fpaddsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [49:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_zero, out_inexact;
    logic [3:0]  out_flags;

    assign out_flags = {out_ovf, out_unf, out_zero, out_inexact};

    fpaddsub_normalize_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_sum      (in_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_zero    (out_zero),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: value = sum * 2^(exp-48); keep 24 significant bits, round half to even
    // on the remainder, then classify the final exponent. Result packed {word, ovf, unf, zero, inexact}.
    function automatic logic [35:0] ref_model(input logic s, input logic [7:0] e, input logic [49:0] m);
        longint unsigned v, keep, rem, half;
        int   p, ee;
        logic inx;
        if (m == '0) return {32'h0, 4'b0010};
        v = 64'(m);
        p = 49;
        while (v[p] == 1'b0) p--;
        ee  = int'(e) + p - 48;
        inx = 1'b0;
        if (p > 23) begin
            keep = v >> (p - 23);
            rem  = v & ((64'd1 << (p - 23)) - 64'd1);
            half = 64'd1 << (p - 24);
            inx  = (rem != 0);
            if (rem > half || (rem == half && keep[0])) keep++;
        end else begin
            keep = v << (23 - p);
        end
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            ee++;
        end
        if (ee <= 0)   return {s, 31'h0, 4'b0101};
        if (ee >= 255) return {s, 8'hFF, 23'h0, 4'b1001};
        return {s, 8'(ee), keep[22:0], 3'b000, inx};
    endfunction

    typedef struct {
        logic [35:0] v;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t        sb[$];
    exp_t        ent;
    int          cyc = 0;
    bit          dir_vld = 1'b0;
    logic [35:0] dir_val = '0;
    bit          lat_mode = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          saw_block = 1'b0;
    bit          prev_stall = 1'b0;
    logic [36:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: inputs and out_ready are stable from posedge+1 to the next posedge,
    // so negedge sees exactly what the next edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_eq("stall_hold", {out_valid, out_result, out_flags}, prev_out);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", out_valid, 1'b0);
                end else begin
                    ent = sb.pop_front();
                    check_eq("result", out_result, ent.v[35:4]);
                    check_eq("flags", out_flags, ent.v[3:0]);
                    if (ent.lat_chk) check_eq("latency", cyc - ent.acc_cyc, 3);
                end
            end
            if (in_valid && in_ready) begin
                ent.v       = dir_vld ? dir_val : ref_model(in_sign, in_exp, in_sum);
                ent.acc_cyc = cyc;
                ent.lat_chk = lat_mode;
                sb.push_back(ent);
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_result, out_flags};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic s, input logic [7:0] e, input logic [49:0] m,
                        input bit has_dir, input logic [35:0] dv);
        bit acc;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sum   = m;
        dir_vld  = has_dir;
        dir_val  = dv;
        acc      = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        dir_vld  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [49:0] rnd_sum();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       return {1'b1, r[48:0]};
            1:       return {2'b01, r[47:0]};
            2:       return r[49:0] >> $urandom_range(0, 49);
            3:       return (50'd1 << 48) | (50'(r[22:0]) << 25) | (50'($urandom_range(0, 1)) << 24);
            default: return ($urandom_range(0, 7) == 0) ? 50'd0 : {1'b1, r[48:26], 1'b1, 25'h0};
        endcase
    endfunction

    function automatic logic [7:0] rnd_exp();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(0, 255));
            1:       return 8'($urandom_range(0, 5));
            2:       return 8'($urandom_range(250, 255));
            default: return 8'($urandom_range(100, 150));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [49:0] s_tie, s_odd, s_ones;
        s_tie  = (50'd1 << 48) | (50'd1 << 24);
        s_odd  = (50'd1 << 48) | (50'd1 << 25) | (50'd1 << 24);
        s_ones = (50'd1 << 48) | (50'h7FFFFF << 25) | (50'd1 << 24);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sum    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_result", out_result, 32'h0);
        check_eq("reset_flags", out_flags, 4'h0);
        check_eq("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // Directed corners, back to back, no backpressure: latency also checked.
        lat_mode = 1'b1;
        send(1'b0, 8'(EXP_BIAS), 50'd1 << 49, 1'b1, {32'h4000_0000, 4'b0000});
        send(1'b1, 8'd130,       50'd1 << 45, 1'b1, {32'hBF80_0000, 4'b0000});
        send(1'b0, 8'(EXP_BIAS), s_tie,       1'b1, {32'h3F80_0000, 4'b0001});
        send(1'b0, 8'(EXP_BIAS), s_odd,       1'b1, {32'h3F80_0002, 4'b0001});
        send(1'b0, 8'(EXP_BIAS), s_ones,      1'b1, {32'h4000_0000, 4'b0001});
        send(1'b1, 8'(EXP_BIAS), 50'd0,       1'b1, {32'h0000_0000, 4'b0010});
        send(1'b0, 8'd254,       50'd1 << 49, 1'b1, {32'h7F80_0000, 4'b1001});
        send(1'b0, 8'd2,         50'd1 << 45, 1'b1, {32'h0000_0000, 4'b0101});
        idle(6);
        lat_mode = 1'b0;

        // Randomized traffic with random output backpressure and input bubbles.
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else send(1'($urandom), rnd_exp(), rnd_sum(), 1'b0, '0);
        end
        idle(1);
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle(8);

        // Stall burst: four back-to-back beats while the sink refuses for several cycles.
        out_ready = 1'b0;
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'($urandom), rnd_exp(), rnd_sum(), 1'b0, '0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);
        check_eq("in_ready_fell", saw_block, 1'b1);
        check_eq("burst_drained", sb.size(), 0);

        // Reset with beats in flight: everything in flight is discarded.
        for (int i = 0; i < 3; i++) send(1'($urandom), rnd_exp(), rnd_sum(), 1'b0, '0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_eq("rst_mid_out_valid", out_valid, 1'b0);
        check_eq("rst_mid_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        idle(8);
        check_eq("rst_mid_quiet", out_valid, 1'b0);

        // A clean beat after the mid-stream reset.
        send(1'b0, 8'(EXP_BIAS), 50'd1 << 49, 1'b1, {32'h4000_0000, 4'b0000});
        idle(6);
        check_eq("final_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
